// File: rtl/matrix_regfile.sv
// matrix_regfile: DEPTH rows of WIDTH bits on the shared matrix data bus.
//
// Each row is split into LANES = WIDTH/ELEM lanes. Writes are lane-masked and
// mark the row valid; reads are registered and presented for one cycle with
// DataValid. A single-cycle Clear starts a sweep that zeroes one row per
// clock, starting on the edge that samples Clear.
//
// Ports
//   Clock      sole clock, rising edge
//   Reset      synchronous, active-high
//   Enable     access request
//   ReadWrite  1 = read, 0 = write (qualified by Enable)
//   Address    row select; values >= DEPTH are out of range
//   LaneMask   per-lane write enables
//   DataIn     write data
//   Clear      request to zero every row
//   DataOut    registered read data, released (high-Z) when DataValid = 0
//   DataValid  read result presented this cycle
//   EntryValid row just read has been written since the last reset/clear
//   Busy       clear sweep in progress; accesses are dropped
//
// state    | meaning
// ---------+-----------------------------------------------------------
// ST_IDLE  | accepting accesses; Clear zeroes row 0 and starts the sweep
// ST_CLEAR | zeroing row sweep_idx_q each cycle, accesses dropped
module matrix_regfile #(
  parameter int WIDTH  = 256,
  parameter int DEPTH  = 4,
  parameter int ELEM   = 16,
  parameter int ADDR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic                   Clock,
  input  logic                   Reset,
  input  logic                   Enable,
  input  logic                   ReadWrite,
  input  logic [ADDR_W-1:0]      Address,
  input  logic [WIDTH/ELEM-1:0]  LaneMask,
  input  logic [WIDTH-1:0]       DataIn,
  input  logic                   Clear,
  output logic [WIDTH-1:0]       DataOut,
  output logic                   DataValid,
  output logic                   EntryValid,
  output logic                   Busy
);

  localparam int LANES     = WIDTH / ELEM;
  localparam bit MULTI_ROW = (DEPTH > 1);

  if ((WIDTH % ELEM) != 0) begin : g_bad_width
    $fatal(1, "matrix_regfile: WIDTH must be a multiple of ELEM");
  end
  if ((DEPTH < 1) || (DEPTH > 64)) begin : g_bad_depth
    $fatal(1, "matrix_regfile: DEPTH must be between 1 and 64");
  end

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_CLEAR = 1'b1
  } state_t;

  state_t              state_q, state_d;
  logic [ADDR_W-1:0]   sweep_idx_q, sweep_idx_d;
  logic [WIDTH-1:0]    mem_q [DEPTH];
  logic [WIDTH-1:0]    mem_d [DEPTH];
  logic [DEPTH-1:0]    valid_q, valid_d;
  logic [WIDTH-1:0]    data_out_q, data_out_d;
  logic                data_valid_q, data_valid_d;
  logic                entry_valid_q, entry_valid_d;

  logic                sweep_last;
  logic                busy;
  logic                zero_en;
  logic [ADDR_W-1:0]   zero_row;
  logic                wr_go;
  logic                rd_go;

  assign sweep_last = (sweep_idx_q == ADDR_W'(DEPTH - 1));

  // State register and all storage.
  always_ff @(posedge Clock) begin
    if (Reset) begin
      state_q       <= ST_IDLE;
      sweep_idx_q   <= '0;
      mem_q         <= '{default: '0};
      valid_q       <= '0;
      data_out_q    <= '0;
      data_valid_q  <= 1'b0;
      entry_valid_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      sweep_idx_q   <= sweep_idx_d;
      mem_q         <= mem_d;
      valid_q       <= valid_d;
      data_out_q    <= data_out_d;
      data_valid_q  <= data_valid_d;
      entry_valid_q <= entry_valid_d;
    end
  end

  // Next-state logic. Row 0 is zeroed on the edge that samples Clear, so the
  // sweep index starts at 1; a single-row array never enters ST_CLEAR.
  always_comb begin
    state_d     = state_q;
    sweep_idx_d = sweep_idx_q;
    unique case (state_q)
      ST_IDLE: begin
        sweep_idx_d = '0;
        if (Clear && MULTI_ROW) begin
          state_d     = ST_CLEAR;
          sweep_idx_d = ADDR_W'(1);
        end
      end
      ST_CLEAR: begin
        if (sweep_last) begin
          state_d     = ST_IDLE;
          sweep_idx_d = '0;
        end else begin
          sweep_idx_d = sweep_idx_q + ADDR_W'(1);
        end
      end
      default: begin
        state_d     = ST_IDLE;
        sweep_idx_d = '0;
      end
    endcase
  end

  // Output / control decode. Clear beats a same-cycle access; anything that
  // arrives during the sweep is dropped.
  always_comb begin
    busy     = 1'b0;
    zero_en  = 1'b0;
    zero_row = '0;
    wr_go    = 1'b0;
    rd_go    = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (Clear) begin
          zero_en = 1'b1;
        end else if (Enable) begin
          wr_go = !ReadWrite;
          rd_go = ReadWrite;
        end
      end
      ST_CLEAR: begin
        busy     = 1'b1;
        zero_en  = 1'b1;
        zero_row = sweep_idx_q;
      end
      default: begin
        busy = 1'b0;
      end
    endcase
  end

  // Storage update and registered read. Rows are matched by comparison rather
  // than indexing so an out-of-range Address simply matches nothing: writes
  // vanish and reads return zero with EntryValid low.
  always_comb begin
    mem_d         = mem_q;
    valid_d       = valid_q;
    data_out_d    = '0;
    data_valid_d  = 1'b0;
    entry_valid_d = 1'b0;
    for (int r = 0; r < DEPTH; r++) begin
      if (zero_en && (zero_row == ADDR_W'(r))) begin
        mem_d[r]   = '0;
        valid_d[r] = 1'b0;
      end else if (wr_go && (Address == ADDR_W'(r)) && (|LaneMask)) begin
        for (int l = 0; l < LANES; l++) begin
          if (LaneMask[l]) begin
            mem_d[r][l*ELEM +: ELEM] = DataIn[l*ELEM +: ELEM];
          end
        end
        valid_d[r] = 1'b1;
      end
    end
    if (rd_go) begin
      data_valid_d = 1'b1;
      for (int r = 0; r < DEPTH; r++) begin
        if (Address == ADDR_W'(r)) begin
          data_out_d    = mem_q[r];
          entry_valid_d = valid_q[r];
        end
      end
    end
  end

  assign DataOut    = data_valid_q ? data_out_q : {WIDTH{1'bz}};
  assign DataValid  = data_valid_q;
  assign EntryValid = entry_valid_q;
  assign Busy       = busy;

endmodule

// File: tb/tb_matrix_regfile.sv
// Bench for matrix_regfile: DEPTH=4 instance tracked by a row-array model
// every cycle, plus a DEPTH=3 instance for out-of-range and reset-mid-sweep.
module tb_matrix_regfile;

  logic         clk = 1'b0;
  always #5 clk = ~clk;

  // DEPTH = 4 instance
  logic         rst, en, rw, clr;
  logic [1:0]   addr;
  logic [15:0]  mask;
  logic [255:0] din;
  wire  [255:0] dout;
  wire          dv, ev, busy;

  // DEPTH = 3 instance
  logic         rst3, en3, rw3, clr3;
  logic [1:0]   addr3;
  logic [15:0]  mask3;
  logic [255:0] din3;
  wire  [255:0] dout3;
  wire          dv3, ev3, busy3;

  matrix_regfile dut (
    .Clock(clk), .Reset(rst), .Enable(en), .ReadWrite(rw), .Address(addr),
    .LaneMask(mask), .DataIn(din), .Clear(clr), .DataOut(dout),
    .DataValid(dv), .EntryValid(ev), .Busy(busy)
  );

  matrix_regfile #(.DEPTH(3)) dut3 (
    .Clock(clk), .Reset(rst3), .Enable(en3), .ReadWrite(rw3), .Address(addr3),
    .LaneMask(mask3), .DataIn(din3), .Clear(clr3), .DataOut(dout3),
    .DataValid(dv3), .EntryValid(ev3), .Busy(busy3)
  );

  int total = 0;
  int bad   = 0;

  task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  // A released bus reads Z on a 4-state simulator and 0 on a 2-state one.
  task automatic check_released(input string name, input logic [255:0] act);
    total++;
    if (!((act === {256{1'bz}}) || (act === 256'd0))) begin
      bad++;
      $display("FAIL %s: got %h want high-Z", name, act);
    end
  endtask

  // ---------------- behavioural model of the DEPTH=4 instance -------------
  logic [255:0] m_mem [4];
  bit           m_vld [4];
  bit           m_dv, m_ev;
  logic [255:0] m_do;
  int           m_sweep_left;
  bit           model_live = 1'b0;

  always @(posedge clk) begin
    if (rst) begin
      for (int r = 0; r < 4; r++) begin
        m_mem[r] = '0;
        m_vld[r] = 1'b0;
      end
      m_dv = 0; m_ev = 0; m_do = '0; m_sweep_left = 0;
      model_live = 1'b1;
    end else if (m_sweep_left > 0) begin
      m_mem[4 - m_sweep_left] = '0;
      m_vld[4 - m_sweep_left] = 1'b0;
      m_sweep_left--;
      m_dv = 0; m_ev = 0;
    end else if (clr) begin
      m_mem[0] = '0;
      m_vld[0] = 1'b0;
      m_sweep_left = 3;
      m_dv = 0; m_ev = 0;
    end else if (en && !rw) begin
      for (int l = 0; l < 16; l++)
        if (mask[l]) m_mem[addr][l*16 +: 16] = din[l*16 +: 16];
      if (mask != 16'd0) m_vld[addr] = 1'b1;
      m_dv = 0; m_ev = 0;
    end else if (en && rw) begin
      m_dv = 1;
      m_do = m_mem[addr];
      m_ev = m_vld[addr];
    end else begin
      m_dv = 0; m_ev = 0;
    end
    #1;
    if (model_live) begin
      check("model_dv", {255'd0, dv}, {255'd0, m_dv});
      check("model_ev", {255'd0, ev}, {255'd0, m_ev});
      check("model_busy", {255'd0, busy}, {255'd0, (m_sweep_left > 0)});
      if (m_dv) check("model_dout", dout, m_do);
      else      check_released("model_dout_z", dout);
    end
  end

  // ---------------- stimulus ----------------------------------------------
  task automatic step(input bit e, input bit r, input logic [1:0] a,
                      input logic [15:0] m, input logic [255:0] d,
                      input bit c, input bit rs);
    en = e; rw = r; addr = a; mask = m; din = d; clr = c; rst = rs;
    @(negedge clk);
  endtask

  task automatic idle();                                   step(0, 0, 2'd0, 16'd0, '0, 0, 0); endtask
  task automatic wr(input logic [1:0] a, input logic [15:0] m, input logic [255:0] d);
    step(1, 0, a, m, d, 0, 0);
  endtask
  task automatic rd(input logic [1:0] a);                  step(1, 1, a, 16'd0, '0, 0, 0); endtask

  task automatic step3(input bit e, input bit r, input logic [1:0] a,
                       input logic [15:0] m, input logic [255:0] d,
                       input bit c, input bit rs);
    en3 = e; rw3 = r; addr3 = a; mask3 = m; din3 = d; clr3 = c; rst3 = rs;
    @(negedge clk);
  endtask

  function automatic logic [255:0] row_pat(input int r);
    logic [15:0] e;
    e = 16'hC000 | 16'(r);
    return {16{e}};
  endfunction

  initial begin : watchdog
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [255:0] pat_a5, pat_mix, d;
    logic [15:0]  m;
    int           n;
    pat_a5  = {16{16'hA5A5}};
    pat_mix = {{12{16'hA5A5}}, {4{16'h1234}}};

    en3 = 0; rw3 = 0; addr3 = 0; mask3 = 0; din3 = '0; clr3 = 0; rst3 = 1;
    step(0, 0, 2'd0, 16'd0, '0, 0, 1);
    step(0, 0, 2'd0, 16'd0, '0, 0, 1);
    rst3 = 0;
    repeat (3) idle();
    check("idle_dv", {255'd0, dv}, 256'd0);
    check("idle_busy", {255'd0, busy}, 256'd0);
    check_released("idle_dout", dout);
    for (int r = 0; r < 4; r++) rd(2'(r));
    check("rst_row3_data", dout, 256'd0);
    check("rst_row3_ev", {255'd0, ev}, 256'd0);

    wr(2'd2, 16'hFFFF, pat_a5);
    rd(2'd2);
    check("full_wr_data", dout, pat_a5);
    check("full_wr_dv", {255'd0, dv}, 256'd1);
    check("full_wr_ev", {255'd0, ev}, 256'd1);
    idle();
    check("hold_one_dv", {255'd0, dv}, 256'd0);
    check_released("hold_one_dout", dout);

    wr(2'd2, 16'h000F, {16{16'h1234}});
    rd(2'd2);
    check("masked_wr", dout, pat_mix);
    wr(2'd2, 16'h0000, {256{1'b1}});
    rd(2'd2);
    check("mask0_noop", dout, pat_mix);

    for (int r = 0; r < 4; r++) wr(2'(r), 16'hFFFF, row_pat(r));
    step(1, 1, 2'd1, 16'd0, '0, 1, 0);
    check("clr_drops_rd", {255'd0, dv}, 256'd0);
    n = 0;
    while (busy && n < 10) begin
      n++;
      if (n == 1) wr(2'd3, 16'hFFFF, {256{1'b1}});
      else        idle();
    end
    check("busy_cycles", 256'(n), 256'd3);
    for (int r = 0; r < 4; r++) rd(2'(r));
    check("cleared_row3", dout, 256'd0);
    check("cleared_row3_ev", {255'd0, ev}, 256'd0);

    for (int r = 0; r < 4; r++) wr(2'(r), 16'hFFFF, row_pat(r));
    for (int r = 0; r < 4; r++) begin
      rd(2'(r));
      check("b2b_dv", {255'd0, dv}, 256'd1);
      check("b2b_data", dout, row_pat(r));
    end
    idle();

    // DEPTH = 3 instance
    step3(1, 0, 2'd3, 16'hFFFF, {256{1'b1}}, 0, 0);
    step3(1, 1, 2'd3, 16'd0, '0, 0, 0);
    check("oor_data", dout3, 256'd0);
    check("oor_dv", {255'd0, dv3}, 256'd1);
    check("oor_ev", {255'd0, ev3}, 256'd0);
    step3(1, 0, 2'd2, 16'hFFFF, row_pat(2), 0, 0);
    step3(0, 0, 2'd0, 16'd0, '0, 1, 0);
    n = 0;
    while (busy3 && n < 10) begin
      n++;
      step3(0, 0, 2'd0, 16'd0, '0, 0, 0);
    end
    check("d3_busy_cycles", 256'(n), 256'd2);
    step3(1, 1, 2'd2, 16'd0, '0, 0, 0);
    check("d3_cleared", dout3, 256'd0);
    step3(0, 0, 2'd0, 16'd0, '0, 1, 0);
    check("d3_sweep_busy", {255'd0, busy3}, 256'd1);
    step3(0, 0, 2'd0, 16'd0, '0, 0, 1);
    check("d3_rst_busy", {255'd0, busy3}, 256'd0);
    step3(1, 0, 2'd1, 16'hFFFF, row_pat(1), 0, 0);
    check("d3_idle_busy", {255'd0, busy3}, 256'd0);
    step3(1, 1, 2'd1, 16'd0, '0, 0, 0);
    check("d3_post_rst_rd", dout3, row_pat(1));
    check("d3_post_rst_ev", {255'd0, ev3}, 256'd1);
    step3(0, 0, 2'd0, 16'd0, '0, 0, 0);

    // randomized traffic on the DEPTH = 4 instance
    for (int i = 0; i < 3000; i++) begin
      for (int k = 0; k < 8; k++) d[k*32 +: 32] = $urandom;
      case ($urandom_range(0, 3))
        0: m = 16'd0;
        1: m = 16'hFFFF;
        default: m = 16'($urandom);
      endcase
      step($urandom_range(0, 9) < 7, $urandom_range(0, 1) == 1, 2'($urandom_range(0, 3)),
           m, d, $urandom_range(0, 39) == 0, $urandom_range(0, 199) == 0);
    end
    idle();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
